// File: rtl/frame_byte_reader_if.sv
// frame_byte_reader_if: frame-buffer pull side plus byte-stream push side of the frame byte reader.
interface frame_byte_reader_if;
  logic [15:0] DataVal;
  logic        DataReady;
  logic        FrameReady;
  logic        DataNext;
  logic        DataFrameReset;
  logic [7:0]  TxByte;
  logic        TxValid;
  logic        TxReady;
  logic        LinkAbort;
  logic        Busy;
  logic        FrameErr;
  logic [15:0] FramesSent;
  modport master (
    input  DataVal, DataReady, FrameReady, TxReady, LinkAbort,
    output DataNext, DataFrameReset, TxByte, TxValid, Busy, FrameErr, FramesSent
  );
  modport slave (
    output DataVal, DataReady, FrameReady, TxReady, LinkAbort,
    input  DataNext, DataFrameReset, TxByte, TxValid, Busy, FrameErr, FramesSent
  );
endinterface

// File: rtl/frame_byte_reader.sv
// frame_byte_reader: pulls 8-word frames from the packet buffer and streams them low byte first,
// with an optional FF FF FF 7F header every SYNC_INTERVAL frames and rewind on abort/underrun.
module frame_byte_reader #(
  parameter int SYNC_INTERVAL = 8,
  parameter int WORD_SETTLE   = 3
) (
  input logic clk,
  input logic rst,
  frame_byte_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, SYNC, LOAD, SEND_LO, SEND_HI, GAP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  hdr_q, hdr_d;
  logic [7:0]  hi_q, hi_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] sync_q, sync_d;
  logic [15:0] frames_q, frames_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_valid_q, tx_valid_d;
  logic        next_q, next_d;
  logic        rewind_q, rewind_d;
  logic        err_q, err_d;
  logic        underrun, abort;
  assign underrun = state_q == LOAD && cnt_q == 8'(WORD_SETTLE) && !bus.DataReady;
  assign abort    = (state_q != IDLE && bus.LinkAbort) || underrun;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    hi_d       = hi_q;
    idx_d      = idx_q;
    sync_d     = sync_q;
    frames_d   = frames_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    next_d     = 1'b0;
    rewind_d   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.FrameReady) begin
        cnt_d = '0;
        if (SYNC_INTERVAL != 0 && sync_q == '0) begin
          state_d    = SYNC;
          hdr_d      = '0;
          tx_byte_d  = 8'hFF;
          tx_valid_d = 1'b1;
        end else state_d = LOAD;
      end
      SYNC: if (bus.TxReady) begin
        hdr_d     = hdr_q + 2'd1;
        tx_byte_d = hdr_q == 2'd2 ? 8'h7F : 8'hFF;
        if (hdr_q == 2'd3) begin
          // counts down across the frame this header precedes, so headers land every SYNC_INTERVAL frames
          sync_d     = 16'(SYNC_INTERVAL);
          tx_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = LOAD;
        end
      end
      LOAD: if (cnt_q == 8'(WORD_SETTLE)) begin
        hi_d       = bus.DataVal[15:8];
        tx_byte_d  = bus.DataVal[7:0];
        tx_valid_d = 1'b1;
        state_d    = SEND_LO;
      end else cnt_d = cnt_q + 8'd1;
      SEND_LO: if (bus.TxReady) begin
        tx_byte_d = hi_q;
        state_d   = SEND_HI;
      end
      SEND_HI: if (bus.TxReady) begin
        tx_valid_d = 1'b0;
        next_d     = 1'b1;
        idx_d      = idx_q + 3'd1;
        cnt_d      = '0;
        state_d    = idx_q == 3'd7 ? GAP : LOAD;
        frames_d   = idx_q == 3'd7 ? frames_q + 16'd1 : frames_q;
        sync_d     = idx_q == 3'd7 && sync_q != '0 ? sync_q - 16'd1 : sync_q;
      end
      GAP: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = cnt_q == 8'(WORD_SETTLE - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over a same-cycle byte acceptance: that byte is treated as never sent
    if (abort) begin
      state_d    = GAP;
      cnt_d      = '0;
      idx_d      = '0;
      sync_d     = sync_q;
      frames_d   = frames_q;
      tx_valid_d = 1'b0;
      next_d     = 1'b0;
      rewind_d   = 1'b1;
      err_d      = underrun;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      hi_q       <= '0;
      idx_q      <= '0;
      sync_q     <= '0;
      frames_q   <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      next_q     <= 1'b0;
      rewind_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      hi_q       <= hi_d;
      idx_q      <= idx_d;
      sync_q     <= sync_d;
      frames_q   <= frames_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      next_q     <= next_d;
      rewind_q   <= rewind_d;
      err_q      <= err_d;
    end
  end
  assign bus.TxByte         = tx_byte_q;
  assign bus.TxValid        = tx_valid_q;
  assign bus.DataNext       = next_q;
  assign bus.DataFrameReset = rewind_q;
  assign bus.FrameErr       = err_q;
  assign bus.FramesSent     = frames_q;
  assign bus.Busy           = state_q != IDLE;
endmodule

// File: tb/tb_frame_byte_reader.sv
// tb_frame_byte_reader: directed scenarios with random data/stalls against a byte-stream model
// built from frame contents and header cadence.
module tb_frame_byte_reader;
  localparam int SI = 2;
  localparam int W  = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  frame_byte_reader_if bus();
  frame_byte_reader #(.SYNC_INTERVAL(SI), .WORD_SETTLE(W)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  logic [15:0] mem [0:255];
  int   wr, rd, fs;
  logic force_nr;
  bit   rnd;
  assign bus.DataReady  = (wr > rd) && !force_nr;
  assign bus.FrameReady = (wr - rd) >= 8;
  always @(posedge clk or posedge rst)
    if (rst) begin
      rd <= 0;
      fs <= 0;
      bus.DataVal <= '0;
    end else begin
      bus.DataVal <= mem[rd[7:0]];
      if (bus.DataFrameReset) rd <= fs;
      else if (bus.DataNext) begin
        rd <= rd + 1;
        if ((rd + 1) % 8 == 0) fs <= rd + 1;
      end
    end
  logic [7:0] rx_q [$];
  int   dn_cnt, dfr_cnt, ferr_cnt, stall_chk, stall_err, dn_bad, dn_gap;
  logic stall_p;
  logic [7:0] byte_p;
  always @(posedge clk)
    if (rst) stall_p = 1'b0;
    else begin
      if (bus.TxValid && bus.TxReady) rx_q.push_back(bus.TxByte);
      if (bus.DataFrameReset) dfr_cnt++;
      if (bus.FrameErr) ferr_cnt++;
      if (bus.DataNext) begin
        if (dn_cnt > 0 && dn_gap < W) dn_bad++;
        dn_cnt++;
        dn_gap = 0;
      end else dn_gap++;
      if (stall_p) begin
        stall_chk++;
        if (!(bus.TxValid === 1'b1 && bus.TxByte === byte_p)) stall_err++;
      end
      stall_p = bus.TxValid && !bus.TxReady;
      byte_p  = bus.TxByte;
    end
  int checks, errors, base, m_done;
  bit m_synced;
  logic [7:0] exp_q [$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    bus.TxReady = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
  endtask
  task automatic model_reset();
    m_done = 0;
    m_synced = 0;
    exp_q.delete();
    base = rx_q.size();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr = 0;
    force_nr = 1'b0;
    bus.LinkAbort = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    model_reset();
  endtask
  task automatic load_frame(input logic [15:0] first, input bit rand_w);
    for (int i = 0; i < 8; i++) begin
      mem[wr[7:0]] = rand_w ? 16'($urandom) : first + 16'(i);
      wr++;
    end
  endtask
  task automatic exp_hdr();
    if (SI != 0 && m_done % SI == 0 && !m_synced) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h7F);
      m_synced = 1;
    end
  endtask
  task automatic exp_words(input int first, input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = mem[first + i];
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask
  task automatic exp_done();
    m_done++;
    m_synced = 0;
  endtask
  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (!(bus.FramesSent == 16'(target) && !bus.Busy && !bus.FrameReady) && n < 4000) begin
      cyc();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 4000), 1);
  endtask
  task automatic wait_rx(input string tag, input int count);
    int n = 0;
    while (rx_q.size() - base < count && n < 1000) begin
      cyc();
      n++;
    end
    chk({tag, "_rx_timeout"}, 32'(n < 1000), 1);
  endtask
  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 32'(rx_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < rx_q.size()) chk({tag, "_byte"}, 32'(rx_q[base + i]), 32'(exp_q[i]));
  endtask
  initial begin
    int d0, f0, e0, s0, n;
    bus.TxReady = 1'b1;
    bus.LinkAbort = 1'b0;
    force_nr = 1'b0;
    rnd = 0;
    wr = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1;
    chk("reset_out", {bus.TxValid, bus.DataNext, bus.DataFrameReset, bus.Busy, bus.FrameErr, bus.TxByte, bus.FramesSent}, 0);
    do_reset();
    // single frame with header
    d0 = dn_cnt;
    load_frame(16'h0100, 0);
    exp_hdr(); exp_words(0, 8); exp_done();
    wait_done("t1", 1);
    check_stream("t1");
    chk("t1_next", 32'(dn_cnt - d0), 8);
    chk("t1_frames", 32'(bus.FramesSent), 1);
    // second frame, no header due: FrameReady-to-TxValid latency
    base = rx_q.size();
    exp_q.delete();
    load_frame(16'h0, 1);
    n = 0;
    do begin cyc(); n++; end while (!bus.TxValid && n < 50);
    chk("t7_latency", 32'(n), W + 2);
    exp_hdr(); exp_words(8, 8); exp_done();
    wait_done("t7", 2);
    check_stream("t7");
    // five queued frames: headers before frames 1,3,5
    do_reset();
    d0 = dn_cnt;
    for (int f = 0; f < 5; f++) load_frame(16'h0, 1);
    for (int f = 0; f < 5; f++) begin exp_hdr(); exp_words(8 * f, 8); exp_done(); end
    wait_done("t2", 5);
    check_stream("t2");
    chk("t2_next", 32'(dn_cnt - d0), 40);
    chk("t2_frames", 32'(bus.FramesSent), 5);
    // random downstream stalls
    do_reset();
    s0 = stall_chk; e0 = stall_err;
    rnd = 1;
    load_frame(16'h0100, 0);
    load_frame(16'h0, 1);
    for (int f = 0; f < 2; f++) begin exp_hdr(); exp_words(8 * f, 8); exp_done(); end
    wait_done("t3", 2);
    rnd = 0;
    check_stream("t3");
    chk("t3_stall_stable", 32'(stall_err - e0), 0);
    chk("t3_stalls_seen", 32'(stall_chk - s0 > 0), 1);
    // LinkAbort after the third word
    do_reset();
    d0 = dn_cnt; f0 = dfr_cnt;
    load_frame(16'h0100, 0);
    exp_hdr(); exp_words(0, 3); exp_hdr(); exp_words(0, 8); exp_done();
    wait_rx("t4", 10);
    bus.LinkAbort = 1'b1;
    cyc();
    bus.LinkAbort = 1'b0;
    wait_done("t4", 1);
    check_stream("t4");
    chk("t4_rewind", 32'(dfr_cnt - f0), 1);
    chk("t4_next", 32'(dn_cnt - d0), 11);
    chk("t4_frames", 32'(bus.FramesSent), 1);
    // underrun at word 5
    do_reset();
    f0 = dfr_cnt; e0 = ferr_cnt;
    load_frame(16'h0, 1);
    exp_hdr(); exp_words(0, 5); exp_hdr(); exp_words(0, 8); exp_done();
    wait_rx("t5", 14);
    force_nr = 1'b1;
    n = 0;
    while (ferr_cnt == e0 && n < 50) begin cyc(); n++; end
    force_nr = 1'b0;
    chk("t5_frame_err", 32'(ferr_cnt - e0), 1);
    chk("t5_rewind", 32'(dfr_cnt - f0), 1);
    chk("t5_frames_hold", 32'(bus.FramesSent), 0);
    n = 0;
    while (bus.Busy && n < 50) begin cyc(); n++; end
    chk("t5_idle", 32'(bus.Busy), 0);
    wait_done("t5", 1);
    check_stream("t5");
    // async reset in SEND_HI
    do_reset();
    load_frame(16'h0100, 0);
    wait_rx("t6", 5);
    f0 = dfr_cnt;
    chk("t6_in_send_hi", 32'(bus.TxValid), 1);
    rst = 1'b1;
    #1;
    chk("t6_async", {bus.TxValid, bus.DataNext, bus.DataFrameReset, bus.Busy, bus.FrameErr, bus.TxByte, bus.FramesSent}, 0);
    cyc();
    rst = 1'b0;
    model_reset();
    exp_hdr(); exp_words(0, 8); exp_done();
    wait_done("t6", 1);
    check_stream("t6");
    chk("t6_no_rewind", 32'(dfr_cnt - f0), 0);
    chk("dn_spacing", 32'(dn_bad), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
